// File: rtl/pixel_write_arbiter.sv
// Two-port round-robin pixel write arbiter with double-buffer flip sequencing.
// Define CLEAR_FRAME_EN to blank all 128 pixels at the start of every frame.
module pixel_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [3:0]  x0,
  input  logic [2:0]  y0,
  input  logic [23:0] rgb0,
  output logic        ack0,
  input  logic        req1,
  input  logic [3:0]  x1,
  input  logic [2:0]  y1,
  input  logic [23:0] rgb1,
  output logic        ack1,
  input  logic        done0,
  input  logic        done1,
  output logic [3:0]  x,
  output logic [2:0]  y,
  output logic        valid,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        flip,
  input  logic        flip_done,
  output logic        busy
);

`ifdef CLEAR_FRAME_EN
  typedef enum logic [1:0] {S_CLEAR, S_DRAW, S_FLIP, S_WAIT_FLIP} state_t;
  localparam state_t FRAME_START = S_CLEAR;
  logic [6:0] clr_addr_q;
`else
  typedef enum logic [1:0] {S_DRAW, S_FLIP, S_WAIT_FLIP} state_t;
  localparam state_t FRAME_START = S_DRAW;
`endif
  localparam logic START_BUSY = (FRAME_START != S_DRAW);

  state_t      state_q;
  logic        ack0_q, ack1_q, valid_q, flip_q, busy_q;
  logic [3:0]  x_q;
  logic [2:0]  y_q;
  logic [23:0] rgb_q;
  logic        flag0_q, flag1_q, flag0_d, flag1_d;
  logic        rr_q, rr_d;
  logic        elig0, elig1, gnt0, gnt1;

  // A port acked this cycle is ineligible next cycle so a held req is not written twice.
  always_comb begin
    elig0 = req0 & ~ack0_q;
    elig1 = req1 & ~ack1_q;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (state_q == S_DRAW) begin
      if (elig0 && elig1) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
    rr_d = rr_q;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
  end

  // Done pulses win over the flip_done clear so a finish that races the swap is kept.
  always_comb begin
    flag0_d = flag0_q;
    flag1_d = flag1_q;
    if (state_q == S_WAIT_FLIP && flip_done) begin
      flag0_d = 1'b0;
      flag1_d = 1'b0;
    end
    if (done0) flag0_d = 1'b1;
    if (done1) flag1_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FRAME_START;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      valid_q <= 1'b0;
      flip_q  <= 1'b0;
      busy_q  <= START_BUSY;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      flag0_q <= 1'b0;
      flag1_q <= 1'b0;
      rr_q    <= 1'b0;
`ifdef CLEAR_FRAME_EN
      clr_addr_q <= '0;
`endif
    end else begin
      ack0_q  <= gnt0;
      ack1_q  <= gnt1;
      valid_q <= 1'b0;
      flip_q  <= 1'b0;
      flag0_q <= flag0_d;
      flag1_q <= flag1_d;
      rr_q    <= rr_d;
      case (state_q)
`ifdef CLEAR_FRAME_EN
        S_CLEAR: begin
          valid_q    <= 1'b1;
          x_q        <= clr_addr_q[3:0];
          y_q        <= clr_addr_q[6:4];
          rgb_q      <= '0;
          clr_addr_q <= clr_addr_q + 7'd1;
          if (clr_addr_q == 7'd127) begin
            state_q <= S_DRAW;
            busy_q  <= 1'b0;
          end
        end
`endif
        S_DRAW: begin
          if (gnt0) begin
            valid_q <= 1'b1;
            x_q     <= x0;
            y_q     <= y0;
            rgb_q   <= rgb0;
          end else if (gnt1) begin
            valid_q <= 1'b1;
            x_q     <= x1;
            y_q     <= y1;
            rgb_q   <= rgb1;
          end else if (flag0_q && flag1_q) begin
            state_q <= S_FLIP;
            flip_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FLIP: state_q <= S_WAIT_FLIP;
        S_WAIT_FLIP: begin
          if (flip_done) begin
            state_q <= FRAME_START;
            busy_q  <= START_BUSY;
          end
        end
        default: state_q <= FRAME_START;
      endcase
    end
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign valid = valid_q;
  assign flip  = flip_q;
  assign busy  = busy_q;
  assign x     = x_q;
  assign y     = y_q;
  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed scenarios plus randomized
// traffic against a frame/flag-level reference model.
module tb_pixel_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  x0 = '0, x1 = '0;
  logic [2:0]  y0 = '0, y1 = '0;
  logic [23:0] rgb0 = '0, rgb1 = '0;
  logic        done0 = 1'b0, done1 = 1'b0, flip_done = 1'b0;
  logic        ack0, ack1, valid, flip, busy;
  logic [3:0]  x;
  logic [2:0]  y;
  logic [7:0]  red, green, blue;

  pixel_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0), .rgb0(rgb0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .rgb1(rgb1), .ack1(ack1),
    .done0(done0), .done1(done1),
    .x(x), .y(y), .valid(valid), .red(red), .green(green), .blue(blue),
    .flip(flip), .flip_done(flip_done), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef CLEAR_FRAME_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame phase, finished-flags, and which port is owed the next tie.
  typedef enum int {M_DRAW, M_FLIP, M_WAIT, M_CLEAR} mphase_t;
  mphase_t     m_phase;
  bit          m_f0, m_f1, m_ack0, m_ack1, m_valid, m_flip, m_busy;
  int          m_next, m_cnt;
  logic [3:0]  m_x;
  logic [2:0]  m_y;
  logic [23:0] m_rgb;

  task automatic model_edge();
    int g;
    if (rst) begin
      m_phase = CLR ? M_CLEAR : M_DRAW;
      m_f0 = 0; m_f1 = 0; m_ack0 = 0; m_ack1 = 0; m_valid = 0; m_flip = 0;
      m_busy = CLR; m_next = 0; m_cnt = 0; m_x = '0; m_y = '0; m_rgb = '0;
      return;
    end
    g = -1;
    m_valid = 0;
    m_flip = 0;
    case (m_phase)
      M_CLEAR: begin
        m_valid = 1; m_x = 4'(m_cnt % 16); m_y = 3'(m_cnt / 16); m_rgb = '0;
        m_cnt++;
        if (m_cnt == 128) begin m_cnt = 0; m_phase = M_DRAW; end
      end
      M_DRAW: begin
        bit c0, c1;
        c0 = req0 && !m_ack0;
        c1 = req1 && !m_ack1;
        if (c0 && c1) g = m_next;
        else if (c0)  g = 0;
        else if (c1)  g = 1;
        if (g == 0) begin m_valid = 1; m_x = x0; m_y = y0; m_rgb = rgb0; m_next = 1; end
        else if (g == 1) begin m_valid = 1; m_x = x1; m_y = y1; m_rgb = rgb1; m_next = 0; end
        else if (m_f0 && m_f1) begin m_phase = M_FLIP; m_flip = 1; end
      end
      M_FLIP: m_phase = M_WAIT;
      M_WAIT: if (flip_done) begin
        m_f0 = 0; m_f1 = 0;
        m_phase = CLR ? M_CLEAR : M_DRAW;
      end
      default: ;
    endcase
    if (done0) m_f0 = 1;
    if (done1) m_f1 = 1;
    m_ack0 = (g == 0);
    m_ack1 = (g == 1);
    m_busy = (m_phase != M_DRAW);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0 = 0; req1 = 0; done0 = 0; done1 = 0; flip_done = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    vectors++;
    if ({valid, ack0, ack1, flip, busy} !== {4'b0000, CLR}) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b expected=%b", {valid, ack0, ack1, flip, busy}, {4'b0000, CLR});
    end
    vectors++;
    if ({x, y, red, green, blue} !== 31'd0) begin
      miscompares++;
      $display("FAIL reset_data got=%h expected=0", {x, y, red, green, blue});
    end
    rst = 0;
  endtask

  task automatic test_single();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_wait_draw busy=%b expected 0", busy); end
    req0 = 1; x0 = 4'd3; y0 = 3'd5; rgb0 = 24'h112233;
    tick();
    vectors++;
    if ({valid, ack0, ack1} !== 3'b110) begin
      miscompares++; $display("FAIL single_ack got=%b expected=110", {valid, ack0, ack1});
    end
    vectors++;
    if ({x, y, red, green, blue} !== {4'd3, 3'd5, 24'h112233}) begin
      miscompares++; $display("FAIL single_data got=%h expected=%h", {x, y, red, green, blue}, {4'd3, 3'd5, 24'h112233});
    end
    tick();  // req still held one cycle past its ack: must not be written again
    vectors++;
    if ({valid, ack0, ack1} !== 3'b000) begin
      miscompares++; $display("FAIL held_no_regrant got=%b expected=000", {valid, ack0, ack1});
    end
    req0 = 0;
    tick();
    vectors++;
    if ({valid, ack0} !== 2'b00) begin
      miscompares++; $display("FAIL single_idle got=%b expected=00", {valid, ack0});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_wait_draw busy=%b expected 0", busy); end
    req0 = 1; x0 = 4'($urandom); y0 = 3'($urandom); rgb0 = 24'($urandom);
    req1 = 1; x1 = 4'($urandom); y1 = 3'($urandom); rgb1 = 24'($urandom);
    for (int k = 0; k < 6; k++) begin
      logic [30:0] exp_data;
      bit          exp0;
      exp0 = (k % 2 == 0);
      exp_data = exp0 ? {x0, y0, rgb0} : {x1, y1, rgb1};
      tick();
      vectors++;
      if ({valid, ack0, ack1} !== {1'b1, exp0, !exp0}) begin
        miscompares++; $display("FAIL rr_grant k=%0d got=%b expected=%b", k, {valid, ack0, ack1}, {1'b1, exp0, !exp0});
      end
      vectors++;
      if ({x, y, red, green, blue} !== exp_data) begin
        miscompares++; $display("FAIL rr_data k=%0d got=%h expected=%h", k, {x, y, red, green, blue}, exp_data);
      end
      if (exp0) begin x0 = 4'($urandom); y0 = 3'($urandom); rgb0 = 24'($urandom); end
      else      begin x1 = 4'($urandom); y1 = 3'($urandom); rgb1 = 24'($urandom); end
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_flip();
    logic [30:0] exp_data;
    done0 = 1; tick(); done0 = 0;
    tick(); tick();
    done1 = 1; tick(); done1 = 0;
    vectors++;
    if ({flip, busy} !== 2'b00) begin miscompares++; $display("FAIL flip_early got=%b expected=00", {flip, busy}); end
    tick();
    vectors++;
    if ({flip, busy} !== 2'b11) begin miscompares++; $display("FAIL flip_pulse got=%b expected=11", {flip, busy}); end
    req0 = 1; x0 = 4'd9; y0 = 3'd2; rgb0 = 24'hA5C3E1;
    exp_data = {4'd9, 3'd2, 24'hA5C3E1};
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({valid, ack0, flip, busy} !== 4'b0001) begin
        miscompares++; $display("FAIL flip_wait i=%0d got=%b expected=0001", i, {valid, ack0, flip, busy});
      end
    end
    flip_done = 1; tick(); flip_done = 0;
    vectors++;
    if ({ack0, busy} !== {1'b0, CLR}) begin
      miscompares++; $display("FAIL flip_release got=%b expected=%b", {ack0, busy}, {1'b0, CLR});
    end
    for (int i = 0; i < 200 && ack0 !== 1'b1; i++) tick();
    vectors++;
    if ({ack0, valid, x, y, red, green, blue} !== {2'b11, exp_data}) begin
      miscompares++; $display("FAIL flip_pending_ack got=%h expected=%h", {ack0, valid, x, y, red, green, blue}, {2'b11, exp_data});
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_coincident();
    done0 = 1; done1 = 1; tick(); done0 = 0; done1 = 0;
    tick(); tick();
    flip_done = 1; done1 = 1; tick(); flip_done = 0; done1 = 0;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL coinc_wait_draw busy=%b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (flip !== 1'b0) begin miscompares++; $display("FAIL coinc_no_flip i=%0d got=%b expected=0", i, flip); end
    end
    done0 = 1; tick(); done0 = 0;
    tick();
    vectors++;
    if ({flip, busy} !== 2'b11) begin miscompares++; $display("FAIL coinc_flip got=%b expected=11", {flip, busy}); end
    tick();
    flip_done = 1; tick(); flip_done = 0;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
  endtask

  task automatic test_reset_mid_wait();
    done0 = 1; done1 = 1; tick(); done0 = 0; done1 = 0;
    tick(); tick();
    req0 = 1; x0 = 4'd7; y0 = 3'd7; rgb0 = 24'hFFFFFF;
    rst = 1; flip_done = 1;
    tick();
    vectors++;
    if ({valid, ack0, ack1, flip, busy} !== {4'b0000, CLR}) begin
      miscompares++; $display("FAIL rst_wait_ctrl got=%b expected=%b", {valid, ack0, ack1, flip, busy}, {4'b0000, CLR});
    end
    vectors++;
    if ({x, y, red, green, blue} !== 31'd0) begin
      miscompares++; $display("FAIL rst_wait_data got=%h expected=0", {x, y, red, green, blue});
    end
    rst = 0; req0 = 0;
    tick();
    flip_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({flip, busy} !== {1'b0, CLR}) begin
        miscompares++; $display("FAIL rst_flags_clear i=%0d got=%b expected=%b", i, {flip, busy}, {1'b0, CLR});
      end
    end
  endtask

`ifdef CLEAR_FRAME_EN
  task automatic test_clear();
    do_reset();
    for (int a = 0; a < 128; a++) begin
      tick();
      vectors++;
      if ({valid, x, y, red, green, blue, busy} !== {1'b1, 4'(a % 16), 3'(a / 16), 24'd0, (a != 127)}) begin
        miscompares++; $display("FAIL clear_sweep a=%0d got=%h", a, {valid, x, y, red, green, blue, busy});
      end
    end
    tick();
    vectors++;
    if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL clear_done got=%b expected=00", {valid, busy}); end
    do_reset();
    for (int a = 0; a <= 40; a++) tick();
    rst = 1; tick(); rst = 0;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL clear_abort got=%b expected=0", valid); end
    tick();
    vectors++;
    if ({valid, x, y} !== 8'b1_0000_000) begin
      miscompares++; $display("FAIL clear_restart got=%b expected=10000000", {valid, x, y});
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if (req0 && m_ack0) begin
        if ($urandom_range(1, 0) == 0) req0 = 0;
        else begin x0 = 4'($urandom); y0 = 3'($urandom); rgb0 = 24'($urandom); end
      end else if (!req0 && $urandom_range(9, 0) < 4) begin
        req0 = 1; x0 = 4'($urandom); y0 = 3'($urandom); rgb0 = 24'($urandom);
      end
      if (req1 && m_ack1) begin
        if ($urandom_range(1, 0) == 0) req1 = 0;
        else begin x1 = 4'($urandom); y1 = 3'($urandom); rgb1 = 24'($urandom); end
      end else if (!req1 && $urandom_range(9, 0) < 4) begin
        req1 = 1; x1 = 4'($urandom); y1 = 3'($urandom); rgb1 = 24'($urandom);
      end
      done0     = ($urandom_range(15, 0) == 0);
      done1     = ($urandom_range(15, 0) == 0);
      flip_done = ($urandom_range(3, 0) == 0);
      rst       = ($urandom_range(699, 0) == 0);
      tick();
      vectors++;
      if ({valid, ack0, ack1, flip, busy} !== {m_valid, m_ack0, m_ack1, m_flip, m_busy}) begin
        miscompares++;
        $display("FAIL rand_ctrl n=%0d got=%b expected=%b", n, {valid, ack0, ack1, flip, busy},
                 {m_valid, m_ack0, m_ack1, m_flip, m_busy});
      end
      if (m_valid) begin
        vectors++;
        if ({x, y, red, green, blue} !== {m_x, m_y, m_rgb}) begin
          miscompares++;
          $display("FAIL rand_data n=%0d got=%h expected=%h", n, {x, y, red, green, blue}, {m_x, m_y, m_rgb});
        end
      end
    end
    rst = 0; req0 = 0; req1 = 0; done0 = 0; done1 = 0; flip_done = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flip();
    test_coincident();
    test_reset_mid_wait();
`ifdef CLEAR_FRAME_EN
    test_clear();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: req0 in 1 / x0 in 4 / y0 in 3 / rgb0 in 24 ({r,g,b}) / ack0 out 1, requester 0 pixel write.
REQ-003 SHALL have ports: req1 in 1 / x1 in 4 / y1 in 3 / rgb1 in 24 / ack1 out 1, requester 1 pixel write.
REQ-004 SHALL have ports: done0 in 1, done1 in 1, one-cycle pulses, requester finished drawing current frame.
REQ-005 SHALL have ports: x out 4, y out 3, valid out 1, red/green/blue out 8 each, write port to display controller.
REQ-006 SHALL have ports: flip out 1, flip request pulse; flip_done in 1, one-cycle pulse, buffers swapped.
REQ-007 SHALL have port: busy out 1, high in any state other than DRAW.

Function
REQ-008 SHALL implement states CLEAR, DRAW, FLIP, WAIT_FLIP; all outputs registered.
REQ-009 Handshake: requester holds req and data stable until ack; ack is a one-cycle pulse; requester drops req or presents new data the cycle after ack.
REQ-010 In DRAW, request sampled at edge n SHALL produce valid=1, matching x/y/rgb and ackN=1 at edge n+1; at most one grant per cycle.
REQ-011 Round-robin: when both req high, grant the port not granted last; single req granted immediately; pointer updates only on grant.
REQ-012 A request whose ack is being output in the current cycle SHALL NOT be granted again in the next cycle (no double-write on held req).
REQ-013 done0/done1 SHALL set sticky flags; when both flags set in DRAW and no grant issued that cycle, go to FLIP.
REQ-014 FLIP SHALL assert flip for exactly one cycle, then enter WAIT_FLIP.
REQ-015 WAIT_FLIP SHALL hold until flip_done=1, then clear both flags and go to CLEAR (macro defined) or DRAW.
REQ-016 A done pulse coincident with flip_done SHALL remain set (set wins over clear); done pulses in other states simply set flags.
REQ-017 Outside DRAW no ack or requester-driven valid SHALL be issued; pending reqs wait, none lost.
REQ-018 flip_done outside WAIT_FLIP SHALL be ignored.

Reset
REQ-019 On rst: valid=0, ack0=ack1=0, flip=0, x=y=0, rgb=0, flags cleared, RR pointer favours port 0 next, state CLEAR (macro defined) else DRAW.
REQ-020 rst mid-CLEAR or mid-WAIT_FLIP SHALL abort immediately to the REQ-019 state; no flip or ack emitted on the reset edge.

Configuration
REQ-021 Macro CLEAR_FRAME_EN defined: CLEAR writes black (rgb=0) to all 128 pixels, address 0..127 with x=addr[3:0], y=addr[6:4], valid=1 every cycle for 128 consecutive cycles, then DRAW.
REQ-022 Macro CLEAR_FRAME_EN undefined: CLEAR state and its counter SHALL not exist; transitions target DRAW directly.

Verification
REQ-023 req0=1,x0=3,y0=5,rgb0=0x112233 in DRAW -> next cycle valid=1,x=3,y=5,red=0x11,green=0x22,blue=0x33,ack0=1; exactly one valid.
REQ-024 req0,req1 held high continuously for 6 cycles (new data after each ack) -> grants alternate 0,1,0,1... starting with 0 after reset.
REQ-025 done0 then done1 three cycles later -> one-cycle flip pulse 2 cycles after done1; busy=1; reqs not acked until flip_done.
REQ-026 flip_done with done1 on same cycle in WAIT_FLIP -> flag1 remains set, flag0 cleared; next flip needs only done0.
REQ-027 CLEAR_FRAME_EN defined, release rst -> 128 valid cycles, rgb=0, x/y sweep (0,0)..(15,7), then DRAW, busy=0.
REQ-028 rst asserted at clear address 40 -> next cycle valid=0, clear restarts from address 0.
